// File: rtl/aes_rkey_cache_if.sv
// Round-key cache bus: expander capture side, playback request side and
// the valid/ready round-key stream toward the cipher datapath.
//   master : driven by the expander / cipher control / cipher datapath
//   slave  : the cache (aes_rkey_cache)
// Signals: load_start, rk_in_valid, rk_in, load_done, keys_valid,
//          play_start, play_dir, play_ack,
//          rk_valid, rk_ready, rk_out, rk_idx, rk_last
interface aes_rkey_cache_if;
  logic         load_start;
  logic         rk_in_valid;
  logic [127:0] rk_in;
  logic         load_done;
  logic         keys_valid;
  logic         play_start;
  logic         play_dir;
  logic         play_ack;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_last;

  modport master (
    output load_start, rk_in_valid, rk_in, play_start, play_dir, rk_ready,
    input  load_done, keys_valid, play_ack, rk_valid, rk_out, rk_idx, rk_last
  );

  modport slave (
    input  load_start, rk_in_valid, rk_in, play_start, play_dir, rk_ready,
    output load_done, keys_valid, play_ack, rk_valid, rk_out, rk_idx, rk_last
  );
endinterface

// File: rtl/aes_rkey_cache.sv
// AES round-key cache. Captures the NR+1 round keys streamed by the key
// expander during a load pass, then replays them on request, forward
// (round 0..NR) or inverse (round NR..0), over a valid/ready stream.
//   clk, reset : clock, synchronous active-high reset
//   bus        : aes_rkey_cache_if.slave (load, playback request, key stream)
//   K          : key length 128/192/256; NR = 10/12/14, NR+1 keys stored
// Optional build macro AES_RKEY_EQINV_EN: inverse playback emits
// InvMixColumns(key) for rounds 1..NR-1 (equivalent inverse cipher keys).
module aes_rkey_cache #(
  parameter int unsigned K = 128
) (
  input logic             clk,
  input logic             reset,
  aes_rkey_cache_if.slave bus
);
  localparam int unsigned NR  = (K == 256) ? 14 : (K == 192) ? 12 : 10;
  localparam int unsigned NK  = NR + 1;
  localparam logic [3:0]  NR4 = 4'(NR);

  typedef enum logic [1:0] {EMPTY, LOAD, READY, PLAY} state_t;

  state_t       state;
  logic [127:0] mem [NK];
  logic [3:0]   wr_ptr, rd_ptr;
  logic         dir_q;
  logic         load_done, keys_valid, rk_valid, rk_last;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;

  logic         ack;
  logic [3:0]   nxt_ptr;
  logic         nxt_dir;
  logic         nxt_last;
  logic [127:0] rd_key;

`ifdef AES_RKEY_EQINV_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] d);
    logic [127:0] r;
    logic [7:0]   s [4];
    logic [7:0]   x2 [4], x4 [4], x8 [4];
    logic [7:0]   m9 [4], mb [4], md [4], me [4];
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        s[i]  = d[127 - 32*c - 8*i -: 8];
        x2[i] = xt(s[i]);
        x4[i] = xt(x2[i]);
        x8[i] = xt(x4[i]);
        m9[i] = x8[i] ^ s[i];
        mb[i] = x8[i] ^ x2[i] ^ s[i];
        md[i] = x8[i] ^ x4[i] ^ s[i];
        me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      r[127 - 32*c -: 32] = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                             m9[0] ^ me[1] ^ mb[2] ^ md[3],
                             md[0] ^ m9[1] ^ me[2] ^ mb[3],
                             mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    end
    return r;
  endfunction
`endif

  // load_start outranks play_start
  assign ack = (state == READY) && bus.play_start && !bus.load_start;

  // Index of the key to be presented next: the start point on acceptance,
  // otherwise one step along the current direction. On the final key the
  // pointer holds so it never leaves 0..NR.
  always_comb begin
    nxt_dir = dir_q;
    nxt_ptr = rd_ptr;
    if (ack) begin
      nxt_dir = bus.play_dir;
      nxt_ptr = bus.play_dir ? NR4 : '0;
    end else if (!rk_last) begin
      nxt_ptr = dir_q ? rd_ptr - 4'd1 : rd_ptr + 4'd1;
    end
    nxt_last = nxt_dir ? (nxt_ptr == '0) : (nxt_ptr == NR4);
    rd_key   = mem[nxt_ptr];
`ifdef AES_RKEY_EQINV_EN
    if (nxt_dir && nxt_ptr != '0 && nxt_ptr != NR4)
      rd_key = inv_mix(rd_key);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset && !bus.load_start && state == LOAD && bus.rk_in_valid)
      mem[wr_ptr] <= bus.rk_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dir_q      <= 1'b0;
      load_done  <= 1'b0;
      keys_valid <= 1'b0;
      rk_valid   <= 1'b0;
      rk_out     <= '0;
      rk_idx     <= '0;
      rk_last    <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (bus.load_start) begin
        state      <= LOAD;
        wr_ptr     <= '0;
        keys_valid <= 1'b0;
        rk_valid   <= 1'b0;
        rk_last    <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (bus.rk_in_valid) begin
              if (wr_ptr == NR4) begin
                state      <= READY;
                load_done  <= 1'b1;
                keys_valid <= 1'b1;
              end else begin
                wr_ptr <= wr_ptr + 4'd1;
              end
            end
          end
          READY: begin
            if (ack) begin
              state    <= PLAY;
              dir_q    <= nxt_dir;
              rd_ptr   <= nxt_ptr;
              rk_valid <= 1'b1;
              rk_out   <= rd_key;
              rk_idx   <= nxt_ptr;
              rk_last  <= nxt_last;
            end
          end
          PLAY: begin
            if (rk_valid && bus.rk_ready) begin
              if (rk_last) begin
                rk_valid <= 1'b0;
                state    <= READY;
              end else begin
                rd_ptr  <= nxt_ptr;
                rk_out  <= rd_key;
                rk_idx  <= nxt_ptr;
                rk_last <= nxt_last;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.play_ack   = ack;
  assign bus.load_done  = load_done;
  assign bus.keys_valid = keys_valid;
  assign bus.rk_valid   = rk_valid;
  assign bus.rk_out     = rk_out;
  assign bus.rk_idx     = rk_idx;
  assign bus.rk_last    = rk_last;
endmodule

// File: tb/tb_aes_rkey_cache.sv
// Bench for aes_rkey_cache: a K=128 and a K=256 instance share stimulus,
// selected by sel. Expected playback beats are queued when a playback is
// requested and compared as the stream transfers them.
module tb_aes_rkey_cache;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sel = 1'b0;
  logic         load_start = 1'b0, rk_in_valid = 1'b0, play_start = 1'b0;
  logic         play_dir = 1'b0, rk_ready = 1'b0;
  logic [127:0] rk_in = '0;

  aes_rkey_cache_if b0 ();
  aes_rkey_cache_if b1 ();

  aes_rkey_cache #(.K(128)) u_dut128 (.clk(clk), .reset(reset), .bus(b0.slave));
  aes_rkey_cache #(.K(256)) u_dut256 (.clk(clk), .reset(reset), .bus(b1.slave));

  assign b0.load_start  = load_start  & ~sel;
  assign b0.rk_in_valid = rk_in_valid & ~sel;
  assign b0.play_start  = play_start  & ~sel;
  assign b0.rk_in       = rk_in;
  assign b0.play_dir    = play_dir;
  assign b0.rk_ready    = rk_ready;
  assign b1.load_start  = load_start  & sel;
  assign b1.rk_in_valid = rk_in_valid & sel;
  assign b1.play_start  = play_start  & sel;
  assign b1.rk_in       = rk_in;
  assign b1.play_dir    = play_dir;
  assign b1.rk_ready    = rk_ready;

  wire         o_load_done  = sel ? b1.load_done  : b0.load_done;
  wire         o_keys_valid = sel ? b1.keys_valid : b0.keys_valid;
  wire         o_play_ack   = sel ? b1.play_ack   : b0.play_ack;
  wire         o_rk_valid   = sel ? b1.rk_valid   : b0.rk_valid;
  wire [127:0] o_rk_out     = sel ? b1.rk_out     : b0.rk_out;
  wire [3:0]   o_rk_idx     = sel ? b1.rk_idx     : b0.rk_idx;
  wire         o_rk_last    = sel ? b1.rk_last    : b0.rk_last;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   idx;
    logic         last;
  } beat_t;

  beat_t        sb [$];
  logic [127:0] keys [15];
  int           vectors = 0;
  int           miscompares = 0;
  int           vcount = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

`ifdef AES_RKEY_EQINV_EN
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model_invmix(input logic [127:0] d);
    logic [7:0]   base [4];
    logic [7:0]   s [4];
    logic [7:0]   o;
    logic [127:0] r = '0;
    base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) s[i] = d[127 - 32*c - 8*i -: 8];
      for (int row = 0; row < 4; row++) begin
        o = '0;
        for (int j = 0; j < 4; j++) o ^= gmul(s[j], base[(j - row) & 3]);
        r[127 - 32*c - 8*row -: 8] = o;
      end
    end
    return r;
  endfunction
`endif

  function automatic logic [127:0] exp_key(input int r, input logic dir, input int nr);
    logic [127:0] k = keys[r];
`ifdef AES_RKEY_EQINV_EN
    if (dir && r != 0 && r != nr) k = model_invmix(k);
`endif
    return k;
  endfunction

  // Stream monitor: sampled on the falling edge, between active edges.
  initial begin
    logic         stalled = 1'b0;
    logic [127:0] pk = '0;
    logic [3:0]   pi = '0;
    logic         pl = 1'b0;
    beat_t        b;
    logic         have;
    forever begin
      @(negedge clk);
      if (o_rk_valid) begin
        vcount++;
        if (stalled) begin
          check("hold_key", o_rk_out, pk);
          check("hold_idx", 128'(o_rk_idx), 128'(pi));
          check("hold_last", 128'(o_rk_last), 128'(pl));
        end
        if (rk_ready) begin
          have = (sb.size() != 0);
          check("beat_expected", 128'(have), 128'(1));
          if (have) begin
            b = sb.pop_front();
            check("beat_key", o_rk_out, b.key);
            check("beat_idx", 128'(o_rk_idx), 128'(b.idx));
            check("beat_last", 128'(o_rk_last), 128'(b.last));
          end
        end
        stalled = !rk_ready;
        pk = o_rk_out;
        pi = o_rk_idx;
        pl = o_rk_last;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic push_seq(input logic dir, input int nr);
    int r;
    for (int i = 0; i <= nr; i++) begin
      r = dir ? nr - i : i;
      sb.push_back('{key: exp_key(r, dir, nr), idx: 4'(r), last: (i == nr)});
    end
  endtask

  task automatic load(input int n, input logic gap);
    load_start = 1'b1;
    @(posedge clk) #1;
    load_start = 1'b0;
    check("load_kv_clear", 128'(o_keys_valid), 128'(0));
    for (int i = 0; i < n; i++) begin
      rk_in_valid = 1'b1;
      rk_in = keys[i];
      @(posedge clk) #1;
      check("load_done", 128'(o_load_done), 128'(i == n - 1));
      if (gap) begin
        rk_in_valid = 1'b0;
        @(posedge clk) #1;
        check("load_done_gap", 128'(o_load_done), 128'(0));
      end
    end
    rk_in_valid = 1'b0;
    if (!gap) begin
      @(posedge clk) #1;
      check("load_done_pulse", 128'(o_load_done), 128'(0));
    end
    check("keys_valid", 128'(o_keys_valid), 128'(1));
  endtask

  task automatic play(input logic dir, input logic [3:0] pat, input logic exp_ack, input int nr);
    int cyc = 0;
    int guard = 0;
    play_start = 1'b1;
    play_dir = dir;
    #1;
    check("play_ack", 128'(o_play_ack), 128'(exp_ack));
    if (exp_ack) push_seq(dir, nr);
    vcount = 0;
    @(posedge clk) #1;
    play_start = 1'b0;
    rk_ready = pat[0];
    while (sb.size() > 0 && guard < 500) begin
      @(posedge clk) #1;
      cyc++;
      guard++;
      rk_ready = pat[2'(cyc % 4)];
    end
    check("play_in_time", 128'(guard < 500), 128'(1));
    check("end_valid", 128'(o_rk_valid), 128'(0));
    rk_ready = 1'b0;
    sb.delete();
  endtask

  initial begin
    int guard;
    keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    repeat (3) @(posedge clk);
    #1;
    check("rst_load_done", 128'(o_load_done), 128'(0));
    check("rst_keys_valid", 128'(o_keys_valid), 128'(0));
    check("rst_rk_valid", 128'(o_rk_valid), 128'(0));
    check("rst_rk_out", o_rk_out, 128'(0));
    check("rst_rk_idx", 128'(o_rk_idx), 128'(0));
    check("rst_rk_last", 128'(o_rk_last), 128'(0));
    reset = 1'b0;
    @(posedge clk) #1;
    play(1'b0, 4'b1111, 1'b0, 10);

    // K=128: back-to-back load, forward and inverse, then backpressure
    load(11, 1'b0);
    play(1'b0, 4'b1111, 1'b1, 10);
    check("fwd_valid_cycles", 128'(vcount), 128'(11));
    play(1'b1, 4'b1111, 1'b1, 10);
    check("inv_valid_cycles", 128'(vcount), 128'(11));
    play(1'b0, 4'b1001, 1'b1, 10);

    // Abort with the idx4 transfer pending
    play_start = 1'b1;
    play_dir = 1'b0;
    rk_ready = 1'b1;
    #1;
    check("abort_play_ack", 128'(o_play_ack), 128'(1));
    push_seq(1'b0, 10);
    @(posedge clk) #1;
    play_start = 1'b0;
    guard = 0;
    while (sb.size() > 7 && guard < 100) begin
      @(posedge clk) #1;
      guard++;
    end
    rk_ready = 1'b0;
    check("abort_pending_idx", 128'(o_rk_idx), 128'(4));
    check("abort_pending_valid", 128'(o_rk_valid), 128'(1));
    load_start = 1'b1;
    @(posedge clk) #1;
    load_start = 1'b0;
    check("abort_valid", 128'(o_rk_valid), 128'(0));
    check("abort_keys_valid", 128'(o_keys_valid), 128'(0));
    check("abort_last", 128'(o_rk_last), 128'(0));
    check("abort_left", 128'(sb.size()), 128'(7));
    sb.delete();
    play(1'b0, 4'b1111, 1'b0, 10);
    load(11, 1'b0);
    play(1'b1, 4'b1001, 1'b1, 10);

    // Reset in the middle of a load
    load_start = 1'b1;
    @(posedge clk) #1;
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rk_in_valid = 1'b1;
      rk_in = ~keys[i];
      @(posedge clk) #1;
    end
    rk_in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;
    check("mid_rst_load_done", 128'(o_load_done), 128'(0));
    check("mid_rst_keys_valid", 128'(o_keys_valid), 128'(0));
    check("mid_rst_rk_valid", 128'(o_rk_valid), 128'(0));
    check("mid_rst_rk_out", o_rk_out, 128'(0));
    check("mid_rst_rk_idx", 128'(o_rk_idx), 128'(0));
    check("mid_rst_rk_last", 128'(o_rk_last), 128'(0));
    play(1'b0, 4'b1111, 1'b0, 10);
    for (int i = 0; i < 11; i++) begin
      rk_in_valid = 1'b1;
      rk_in = keys[i];
      @(posedge clk) #1;
      check("ignored_strobe_done", 128'(o_load_done), 128'(0));
    end
    rk_in_valid = 1'b0;
    check("ignored_strobe_kv", 128'(o_keys_valid), 128'(0));
    play(1'b0, 4'b1111, 1'b0, 10);
    load(11, 1'b0);
    play(1'b0, 4'b1111, 1'b1, 10);

    // K=256 with a gapped load
    sel = 1'b1;
    for (int i = 0; i < 15; i++) keys[i] = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk) #1;
    play(1'b0, 4'b1111, 1'b0, 14);
    load(15, 1'b1);
    play(1'b0, 4'b1111, 1'b1, 14);
    check("k256_valid_cycles", 128'(vcount), 128'(15));
    play(1'b1, 4'b1001, 1'b1, 14);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
